// File: rtl/seg_carry_adder_pipe_pkg.sv
// Shared definitions for the segmented carry adder pipeline.
// Provides default widths, the approximation-depth clamp and the stage payload type.
package seg_carry_adder_pipe_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_SEG   = 8;
  localparam int unsigned DEF_AW    = 6;
  localparam int unsigned DEF_NSEG  = DEF_WIDTH / DEF_SEG;

  // One pipeline slot: resolved low sum bits, carry into the next segment,
  // effective approximation depth, and the not-yet-consumed operand bits
  // (right-aligned, consumed bits shifted out so they stop toggling).
  typedef struct packed {
    logic [DEF_WIDTH-1:0] sum;
    logic                 carry;
    logic [DEF_AW-1:0]    k;
    logic [DEF_WIDTH-1:0] rem_a;
    logic [DEF_WIDTH-1:0] rem_b;
  } stage_t;

  // Saturate the requested approximation depth at the operand width.
  function automatic logic [DEF_AW-1:0] clamp_k(input logic [DEF_AW-1:0] approx);
    if ({1'b0, approx} > (DEF_AW + 1)'(DEF_WIDTH)) begin
      return DEF_AW'(DEF_WIDTH);
    end
    return approx;
  endfunction

endpackage

// File: rtl/seg_carry_adder_pipe_if.sv
// Operand/result handshake bundle for the segmented adder.
//   in_valid/in_ready  : operand beat handshake (in_a, in_b, in_cin, in_approx)
//   out_valid/out_ready: result handshake (out_sum, out_cout)
// master = operand issue / result consumer side, slave = adder.
interface seg_carry_adder_pipe_if
  import seg_carry_adder_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned AW    = DEF_AW
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic [AW-1:0]    in_approx;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_approx, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_approx, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );

endinterface

// File: rtl/seg_carry_adder_pipe_seg_add.sv
// One SEG-bit slice of propagate/carry cells.
//   a_seg, b_seg : operand bits of this slice
//   cin          : carry into the slice LSB
//   offset       : global bit index of the slice LSB
//   k            : bits below this global index are OR-approximated
//   sum_seg, cout: slice sum and carry out of the slice MSB
module seg_carry_adder_pipe_seg_add
  import seg_carry_adder_pipe_pkg::*;
#(
  parameter int unsigned SEG = DEF_SEG,
  parameter int unsigned AW  = DEF_AW
) (
  input  logic [SEG-1:0] a_seg,
  input  logic [SEG-1:0] b_seg,
  input  logic           cin,
  input  logic [AW-1:0]  offset,
  input  logic [AW-1:0]  k,
  output logic [SEG-1:0] sum_seg,
  output logic           cout
);

  logic          c;
  logic          p;
  logic [AW:0]   gi;

  // Ripple through the slice; approximate bits OR and only the topmost one
  // (global bit k-1) seeds the carry into the exact region.
  always_comb begin
    sum_seg = '0;
    c       = cin;
    p       = 1'b0;
    gi      = '0;
    for (int j = 0; j < SEG; j++) begin
      gi = (AW + 1)'(offset) + (AW + 1)'(j);
      p  = a_seg[j] ^ b_seg[j];
      if (gi < (AW + 1)'(k)) begin
        sum_seg[j] = a_seg[j] | b_seg[j];
        c          = ((gi + (AW + 1)'(1)) == (AW + 1)'(k)) ? (a_seg[j] & b_seg[j]) : 1'b0;
      end else begin
        sum_seg[j] = p ^ c;
        c          = p ? c : a_seg[j];
      end
    end
    cout = c;
  end

endmodule

// File: rtl/seg_carry_adder_pipe.sv
// Pipelined segmented adder with per-operation lower-part-OR approximation.
// One SEG-bit segment is resolved per stage; NSEG stages deep, 1 beat/cycle.
//   clk, rst_n : clock and async active-low reset
//   flush      : synchronous clear of every in-flight beat (wins over accept)
//   bus        : operand/result handshakes (slave side)
module seg_carry_adder_pipe
  import seg_carry_adder_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SEG   = DEF_SEG,
  parameter int unsigned AW    = DEF_AW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  seg_carry_adder_pipe_if.slave bus
);

  localparam int unsigned NSEG = WIDTH / SEG;

  stage_t          st_q [NSEG];
  stage_t          st_d [NSEG];
  stage_t          nxt  [NSEG];
  logic [NSEG-1:0] v_q;
  logic [NSEG-1:0] v_d;
  logic [NSEG-1:0] load_c;
  logic            down_adv;
  logic            in_ready_c;

  // Per-stage segment adder: resolves segment s from the previous slot.
  for (genvar s = 0; s < NSEG; s++) begin : g_stage
    stage_t         src;
    logic [SEG-1:0] seg_sum;
    logic           seg_cout;

    if (s == 0) begin : g_src_in
      assign src = '{sum:   '0,
                     carry: bus.in_cin,
                     k:     clamp_k(bus.in_approx),
                     rem_a: bus.in_a,
                     rem_b: bus.in_b};
    end else begin : g_src_prev
      assign src = st_q[s-1];
    end

    seg_carry_adder_pipe_seg_add #(
      .SEG (SEG),
      .AW  (AW)
    ) u_seg_add (
      .a_seg   (src.rem_a[SEG-1:0]),
      .b_seg   (src.rem_b[SEG-1:0]),
      .cin     (src.carry),
      .offset  (AW'(s * SEG)),
      .k       (src.k),
      .sum_seg (seg_sum),
      .cout    (seg_cout)
    );

    assign nxt[s] = '{sum:   src.sum | (DEF_WIDTH'(seg_sum) << (s * SEG)),
                      carry: seg_cout,
                      k:     src.k,
                      rem_a: src.rem_a >> SEG,
                      rem_b: src.rem_b >> SEG};
  end

  // Advance chain, evaluated from the output back to the input so that a
  // stage can refill in the same cycle it hands its beat onward.
  always_comb begin
    load_c   = '0;
    v_d      = v_q;
    down_adv = v_q[NSEG-1] & bus.out_ready;
    for (int s = NSEG - 1; s > 0; s--) begin
      load_c[s] = v_q[s-1] & (~v_q[s] | down_adv);
      v_d[s]    = load_c[s] | (v_q[s] & ~down_adv);
      down_adv  = load_c[s];
    end
    load_c[0]  = bus.in_valid & ~flush & (~v_q[0] | down_adv);
    v_d[0]     = load_c[0] | (v_q[0] & ~down_adv);
    in_ready_c = flush | ~v_q[0] | down_adv;
    if (flush) begin
      v_d = '0;
    end
  end

  // Data slots only change on a load; a stalled output slot holds its value.
  always_comb begin
    for (int s = 0; s < NSEG; s++) begin
      st_d[s] = load_c[s] ? nxt[s] : st_q[s];
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int s = 0; s < NSEG; s++) begin
        st_q[s] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int s = 0; s < NSEG; s++) begin
        st_q[s] <= st_d[s];
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = v_q[NSEG-1];
  assign bus.out_sum   = st_q[NSEG-1].sum;
  assign bus.out_cout  = st_q[NSEG-1].carry;

endmodule
